io_port: RTL and testbench

CPU-side I/O responder for the Nandy core: consumes the `RD`, `WR` and active-low `nSIG[7:0]` strobes that instruction decode produces, and services them with two 4-entry byte FIFOs. The TX FIFO carries bytes from CPU to an external device; the RX FIFO carries bytes from the device to the CPU. A status byte and sticky error flags are readable through a one-shot status mode. The block sits between the decode/accumulator datapath and the board-level peripheral link.

---
 rtl/io_port.sv | 175 +++++++++++++++++
 tb/tb_io_port.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_port.sv
// CPU-side I/O responder: decodes RD/WR/nSIG strobes and services them with
// 4-entry TX and RX byte FIFOs plus a one-shot status read mode.
module io_port (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] nsig,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_avail
);

    typedef enum logic {
        MODE_DATA   = 1'b0,
        MODE_STATUS = 1'b1
    } mode_t;

    mode_t       mode;

    logic [7:0]  tx_mem [4];
    logic [1:0]  tx_wp;
    logic [1:0]  tx_rp;
    logic [2:0]  tx_cnt;

    logic [7:0]  rx_mem [4];
    logic [1:0]  rx_wp;
    logic [1:0]  rx_rp;
    logic [2:0]  rx_cnt;

    logic        ovf;
    logic        unf;

    logic [7:0]  sig;
    logic        unused_sig;

    logic        tx_full;
    logic        rx_full;
    logic        rx_empty;
    logic        tx_flush;
    logic        rx_flush;
    logic        enter_status;
    logic        clr_flags;
    logic        rd_data;
    logic        rd_status;

    logic        tx_push;
    logic        tx_pop;
    logic        rx_push;
    logic        rx_pop;
    logic        set_ovf;
    logic        set_unf;

    logic [7:0]  status;

    assign sig          = ~nsig;
    assign unused_sig   = ^sig[7:4];

    assign tx_flush     = sig[0];
    assign rx_flush     = sig[1];
    assign enter_status = sig[2];
    assign clr_flags    = sig[3];

    assign tx_full      = (tx_cnt == 3'd4);
    assign rx_full      = (rx_cnt == 3'd4);
    assign rx_empty     = (rx_cnt == 3'd0);

    assign tx_valid     = (tx_cnt != 3'd0);
    assign tx_data      = tx_mem[tx_rp];
    assign rx_ready     = ~rx_full;
    assign rx_avail     = ~rx_empty;

    assign rd_data      = rd & (mode == MODE_DATA);
    assign rd_status    = rd & (mode == MODE_STATUS);

    // Fullness is judged on the state before the edge; a flush discards any
    // same-cycle push/pop and suppresses the flag it would otherwise raise.
    assign tx_push      = wr & ~tx_full & ~tx_flush;
    assign tx_pop       = tx_valid & tx_ready & ~tx_flush;
    assign rx_push      = rx_valid & rx_ready & ~rx_flush;
    assign rx_pop       = rd_data & ~rx_empty & ~rx_flush;
    assign set_ovf      = wr & tx_full & ~tx_flush;
    assign set_unf      = rd_data & rx_empty & ~rx_flush;

    assign status       = {unf, ovf, tx_cnt, rx_cnt};

    always_comb begin
        rdata = '0;
        if (rd_status) begin
            rdata = status;
        end else if (rd_data && !rx_empty) begin
            rdata = rx_mem[rx_rp];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode   <= MODE_DATA;
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                tx_mem[i] <= '0;
                rx_mem[i] <= '0;
            end
        end else begin
            // TX FIFO
            if (tx_flush) begin
                tx_wp  <= '0;
                tx_rp  <= '0;
                tx_cnt <= '0;
            end else begin
                if (tx_push) begin
                    tx_mem[tx_wp] <= wdata;
                    tx_wp         <= tx_wp + 2'd1;
                end
                if (tx_pop) begin
                    tx_rp <= tx_rp + 2'd1;
                end
                tx_cnt <= tx_cnt + {2'b00, tx_push} - {2'b00, tx_pop};
            end

            // RX FIFO
            if (rx_flush) begin
                rx_wp  <= '0;
                rx_rp  <= '0;
                rx_cnt <= '0;
            end else begin
                if (rx_push) begin
                    rx_mem[rx_wp] <= rx_data;
                    rx_wp         <= rx_wp + 2'd1;
                end
                if (rx_pop) begin
                    rx_rp <= rx_rp + 2'd1;
                end
                rx_cnt <= rx_cnt + {2'b00, rx_push} - {2'b00, rx_pop};
            end

            // A new error in the same cycle as a clear is still recorded
            if (clr_flags) begin
                ovf <= set_ovf;
                unf <= set_unf;
            end else begin
                ovf <= ovf | set_ovf;
                unf <= unf | set_unf;
            end

            case (mode)
                MODE_DATA: begin
                    if (enter_status) begin
                        mode <= MODE_STATUS;
                    end
                end
                MODE_STATUS: begin
                    if (rd && !enter_status) begin
                        mode <= MODE_DATA;
                    end
                end
                default: mode <= MODE_DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port.sv
// Directed bench for io_port: FIFO fill/drain, under/overflow, status mode,
// flush/push collisions and asynchronous reset.
module tb_io_port;

    logic       clk;
    logic       rst;
    logic       rd;
    logic       wr;
    logic [7:0] nsig;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_avail;

    int n_checks = 0;
    int n_pass   = 0;

    io_port dut (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd),
        .wr       (wr),
        .nsig     (nsig),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_avail (rx_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enter status mode via SIG2, then read the status byte once
    task automatic status_chk(input string tag, input logic [7:0] exp);
        nsig = ~8'h04;
        tick();
        nsig = 8'hFF;
        rd   = 1'b1;
        #1;
        check(tag, rdata, exp);
        tick();
        rd   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rd       = 1'b0;
        wr       = 1'b0;
        nsig     = 8'hFF;
        wdata    = 8'h00;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_tx_data",  tx_data, 8'h00);
        check("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        check("rst_rx_avail", {7'b0, rx_avail}, 8'h00);
        check("rst_rdata",    rdata, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // TX fill past full with device stalled
        for (int i = 0; i < 5; i++) begin
            wr    = 1'b1;
            wdata = 8'h11 * (i + 1);
            tick();
        end
        wr = 1'b0;
        check("tx_valid_full", {7'b0, tx_valid}, 8'h01);
        status_chk("status_tx4_ovf", 8'h60);

        // Device drains in order
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tx_drain", tx_data, 8'h11 * (i + 1));
            tick();
        end
        check("tx_valid_empty", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;

        // RX push two, CPU reads two, then underflow
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        tick();
        rx_data  = 8'h5A;
        tick();
        rx_valid = 1'b0;
        check("rx_avail_2", {7'b0, rx_avail}, 8'h01);
        rd = 1'b1;
        #1;
        check("rx_rd0", rdata, 8'hA5);
        tick();
        check("rx_rd1", rdata, 8'h5A);
        tick();
        rd = 1'b0;
        check("rx_avail_0", {7'b0, rx_avail}, 8'h00);
        rd = 1'b1;
        #1;
        check("rx_rd_empty", rdata, 8'h00);
        tick();
        rd = 1'b0;
        status_chk("status_unf_ovf", 8'hC0);
        nsig = ~8'h08;
        tick();
        nsig = 8'hFF;

        // Build RX=2, TX=3, ovf=1
        for (int i = 0; i < 5; i++) begin
            wr       = 1'b1;
            wdata    = 8'hB1 + 8'(i);
            rx_valid = (i < 2);
            rx_data  = 8'(i + 1);
            tick();
        end
        wr       = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("tx_head_b2", tx_data, 8'hB2);
        status_chk("status_5a", 8'h5A);
        rd = 1'b1;
        #1;
        check("rx_head_after_status", rdata, 8'h01);
        tick();
        rd = 1'b0;

        // Full TX: write collides with device pop, write still rejected
        nsig = ~8'h08;
        tick();
        nsig  = 8'hFF;
        wr    = 1'b1;
        wdata = 8'hC5;
        tick();
        wdata    = 8'h99;
        tx_ready = 1'b1;
        #1;
        check("tx_head_b2_full", tx_data, 8'hB2);
        tick();
        wr       = 1'b0;
        tx_ready = 1'b0;
        check("tx_head_b3", tx_data, 8'hB3);
        status_chk("status_full_pop", 8'h59);
        nsig = ~8'h08;
        tick();
        nsig = 8'hFF;
        status_chk("status_cleared", 8'h19);

        // Flush coincident with write to a full TX
        wr    = 1'b1;
        wdata = 8'hD1;
        tick();
        nsig  = ~8'h01;
        wdata = 8'h77;
        tick();
        wr   = 1'b0;
        nsig = 8'hFF;
        check("tx_valid_flush", {7'b0, tx_valid}, 8'h00);
        status_chk("status_flush", 8'h01);

        // Async reset mid-stream
        wr       = 1'b1;
        wdata    = 8'hE1;
        rx_valid = 1'b1;
        rx_data  = 8'hF1;
        tick();
        rx_valid = 1'b0;
        wdata    = 8'hE2;
        tick();
        wr = 1'b0;
        check("pre_rst_tx_valid", {7'b0, tx_valid}, 8'h01);
        check("pre_rst_tx_data",  tx_data, 8'hE1);
        check("pre_rst_rx_avail", {7'b0, rx_avail}, 8'h01);
        #1;
        rst = 1'b1;
        rd  = 1'b1;
        #1;
        check("arst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("arst_tx_data",  tx_data, 8'h00);
        check("arst_rx_avail", {7'b0, rx_avail}, 8'h00);
        check("arst_rx_ready", {7'b0, rx_ready}, 8'h01);
        check("arst_rdata",    rdata, 8'h00);
        rd = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        status_chk("status_after_rst", 8'h00);

        // RX full blocks the device, then SIG1 flushes
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_data = 8'h30 + 8'(i);
            tick();
        end
        check("rx_ready_full", {7'b0, rx_ready}, 8'h00);
        rx_valid = 1'b0;
        status_chk("status_rx4", 8'h04);
        nsig = ~8'h02;
        tick();
        nsig = 8'hFF;
        status_chk("status_rx_flush", 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
